// File: rtl/rvh_noc_pkg.sv
// Shared NoC types used by the local-port injection logic.
package rvh_noc_pkg;

   localparam int VC_ID_NUM_MAX_W = 3;

   typedef logic [31:0] flit_payload_t;
   typedef logic [2:0]  io_port_t;

endpackage

// File: rtl/vnet_local_inject_arbiter_pkg.sv
// Constants and FSM state type for the local-port injection arbiter.
package vnet_local_inject_arbiter_pkg;

   localparam int VC_DEPTH_MAX = 4;
   localparam int CRD_W        = $clog2(VC_DEPTH_MAX + 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } inject_state_e;

endpackage

// File: rtl/vnet_local_inject_arbiter_if.sv
// Requester-side flit bus, router-side tx/credit signals and debug taps of the injection arbiter.
interface vnet_local_inject_arbiter_if
   import rvh_noc_pkg::*;
   import vnet_local_inject_arbiter_pkg::*;
#(
   parameter int REQ_NUM = 4,
   parameter int VC_NUM  = 4,
   parameter int VC_ID_W = VC_ID_NUM_MAX_W
);
   // Handshake: flit r transfers in a cycle where req_v_i[r] && req_rdy_o[r]; a requester keeps
   // its flit fields stable until then, and req_rdy_o is never high for a non-valid requester.
   logic [REQ_NUM-1:0] req_v_i;
   logic [REQ_NUM-1:0] req_rdy_o;
   flit_payload_t      req_flit_i  [REQ_NUM];
   logic [REQ_NUM-1:0] req_head_i;
   logic [REQ_NUM-1:0] req_tail_i;
   logic [VC_ID_W-1:0] req_vc_id_i [REQ_NUM];
   io_port_t           req_lar_i   [REQ_NUM];

   logic               tx_flit_pend_o;
   logic               tx_flit_v_o;
   flit_payload_t      tx_flit_o;
   logic [VC_ID_W-1:0] tx_flit_vc_id_o;
   io_port_t           tx_flit_look_ahead_routing_o;

   logic               rx_lcrd_v_i;
   logic [VC_ID_W-1:0] rx_lcrd_id_i;
   logic               credit_err_o;

   inject_state_e      dbg_state;
   logic [CRD_W-1:0]   dbg_credit [VC_NUM];

   modport master (
      output req_v_i, req_flit_i, req_head_i, req_tail_i, req_vc_id_i, req_lar_i,
      output rx_lcrd_v_i, rx_lcrd_id_i,
      input  req_rdy_o, tx_flit_pend_o, tx_flit_v_o, tx_flit_o, tx_flit_vc_id_o,
      input  tx_flit_look_ahead_routing_o, credit_err_o, dbg_state, dbg_credit
   );

   modport slave (
      input  req_v_i, req_flit_i, req_head_i, req_tail_i, req_vc_id_i, req_lar_i,
      input  rx_lcrd_v_i, rx_lcrd_id_i,
      output req_rdy_o, tx_flit_pend_o, tx_flit_v_o, tx_flit_o, tx_flit_vc_id_o,
      output tx_flit_look_ahead_routing_o, credit_err_o, dbg_state, dbg_credit
   );

endinterface

// File: rtl/vnet_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N.
module vnet_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_v
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_v   = 1'b0;
      idx     = '0;
      if (en) begin
         for (int i = 0; i < N; i++) begin
            idx = IDX_W'((int'(ptr) + i) % N);
            if (!gnt_v && req[idx]) begin
               gnt_v    = 1'b1;
               gnt_idx  = idx;
               gnt[idx] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/vnet_local_inject_arbiter.sv
// Wormhole-aware round-robin sharing of one router local input port, with per-VC credit tracking.
module vnet_local_inject_arbiter
   import rvh_noc_pkg::*;
   import vnet_local_inject_arbiter_pkg::*;
#(
   parameter int REQ_NUM  = 4,
   parameter int VC_NUM   = 4,
   parameter int VC_DEPTH = 4,
   parameter int VC_ID_W  = VC_ID_NUM_MAX_W
) (
   input logic clk,
   input logic rstn,
   vnet_local_inject_arbiter_if.slave bus
);

   localparam int               IDX_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
   localparam int               VCI_W    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(VC_DEPTH);
   localparam logic [VC_ID_W:0] VC_LIMIT = (VC_ID_W + 1)'(VC_NUM);

   inject_state_e      state_q, state_d;
   logic [IDX_W-1:0]   owner_q, rr_ptr_q;
   logic [CRD_W-1:0]   cred_q [VC_NUM];
   logic [CRD_W-1:0]   cred_d [VC_NUM];
   logic               err_q, err_d;
   logic [REQ_NUM-1:0] elig, arb_req, arb_gnt, rdy;
   logic [IDX_W-1:0]   arb_idx, acc_idx;
   logic               arb_v, acc_v, acc_tail;
   logic [VC_ID_W-1:0] acc_vc;
   logic [VC_NUM-1:0]  crd_inc, crd_dec;

   logic               tx_v_q;
   flit_payload_t      tx_flit_q;
   logic [VC_ID_W-1:0] tx_vc_q;
   io_port_t           tx_lar_q;

   // Eligibility uses only the registered counters; a credit returned now helps next cycle.
   always_comb begin
      elig    = '0;
      arb_req = '0;
      for (int r = 0; r < REQ_NUM; r++) begin
         elig[r]    = bus.req_v_i[r] && ({1'b0, bus.req_vc_id_i[r]} < VC_LIMIT) &&
                      (cred_q[bus.req_vc_id_i[r][VCI_W-1:0]] != '0);
         arb_req[r] = elig[r] && bus.req_head_i[r];
      end
   end

   vnet_rr_arbiter #(.N(REQ_NUM), .IDX_W(IDX_W)) u_rr (
      .req     (arb_req),
      .ptr     (rr_ptr_q),
      .en      (state_q == ST_IDLE),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_v   (arb_v)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q <= state_d;
         if (acc_v) owner_q <= acc_idx;
         if (acc_v && acc_tail)
            rr_ptr_q <= (acc_idx == IDX_W'(REQ_NUM - 1)) ? '0 : acc_idx + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (acc_v && !acc_tail) state_d = ST_LOCKED;
         ST_LOCKED: if (acc_v && acc_tail)  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rdy     = '0;
      acc_idx = owner_q;
      acc_v   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rdy     = arb_gnt;
            acc_idx = arb_idx;
            acc_v   = arb_v;
         end
         ST_LOCKED: begin
            if (elig[owner_q]) begin
               rdy[owner_q] = 1'b1;
               acc_v        = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign acc_tail = bus.req_tail_i[acc_idx];
   assign acc_vc   = bus.req_vc_id_i[acc_idx];

   // A send and a return on the same VC cancel; a return into a full counter is dropped and flagged.
   always_comb begin
      err_d   = err_q;
      crd_inc = '0;
      crd_dec = '0;
      if (state_q == ST_IDLE && |(bus.req_v_i & ~bus.req_head_i)) err_d = 1'b1;
      if (bus.rx_lcrd_v_i && ({1'b0, bus.rx_lcrd_id_i} >= VC_LIMIT)) err_d = 1'b1;
      for (int v = 0; v < VC_NUM; v++) begin
         cred_d[v]  = cred_q[v];
         crd_dec[v] = acc_v && (acc_vc == VC_ID_W'(v));
         crd_inc[v] = bus.rx_lcrd_v_i && (bus.rx_lcrd_id_i == VC_ID_W'(v));
         if (crd_inc[v] && !crd_dec[v]) begin
            if (cred_q[v] == CRD_FULL) err_d = 1'b1;
            else cred_d[v] = cred_q[v] + 1'b1;
         end else if (crd_dec[v] && !crd_inc[v]) begin
            cred_d[v] = cred_q[v] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int v = 0; v < VC_NUM; v++) cred_q[v] <= CRD_FULL;
         err_q     <= 1'b0;
         tx_v_q    <= 1'b0;
         tx_flit_q <= '0;
         tx_vc_q   <= '0;
         tx_lar_q  <= '0;
      end else begin
         cred_q <= cred_d;
         err_q  <= err_d;
         tx_v_q <= acc_v;
         if (acc_v) begin
            tx_flit_q <= bus.req_flit_i[acc_idx];
            tx_vc_q   <= acc_vc;
            tx_lar_q  <= bus.req_lar_i[acc_idx];
         end
      end
   end

   assign bus.req_rdy_o                    = rdy;
   assign bus.tx_flit_pend_o               = |bus.req_v_i;
   assign bus.tx_flit_v_o                  = tx_v_q;
   assign bus.tx_flit_o                    = tx_flit_q;
   assign bus.tx_flit_vc_id_o              = tx_vc_q;
   assign bus.tx_flit_look_ahead_routing_o = tx_lar_q;
   assign bus.credit_err_o                 = err_q;
   assign bus.dbg_state                    = state_q;
   assign bus.dbg_credit                   = cred_q;

endmodule

// File: tb/tb_vnet_local_inject_arbiter.sv
// Bench for the local-port injection arbiter: directed scenarios plus random traffic against a queue model.
module tb_vnet_local_inject_arbiter;
  import rvh_noc_pkg::*;
  import vnet_local_inject_arbiter_pkg::*;

  localparam int REQ_NUM  = 4;
  localparam int VC_NUM   = 4;
  localparam int VC_DEPTH = 4;
  localparam int VC_ID_W  = VC_ID_NUM_MAX_W;
  localparam int TXW      = $bits(flit_payload_t) + VC_ID_W + $bits(io_port_t);

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  vnet_local_inject_arbiter_if #(.REQ_NUM(REQ_NUM), .VC_NUM(VC_NUM), .VC_ID_W(VC_ID_W)) bus ();

  vnet_local_inject_arbiter #(
    .REQ_NUM(REQ_NUM), .VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH), .VC_ID_W(VC_ID_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic [TXW-1:0] exp_q[$];
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_cred[VC_NUM];
  bit m_err;
  bit m_exp_v;
  int m_last_win = -1;

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    for (int v = 0; v < VC_NUM; v++) m_cred[v] = VC_DEPTH;
    m_err    = 1'b0;
    m_exp_v  = 1'b0;
    exp_q.delete();
  endtask

  function automatic bit can_send(input int r);
    int vc;
    vc = int'(bus.req_vc_id_i[r]);
    return (vc < VC_NUM) && (m_cred[vc] > 0);
  endfunction

  function automatic int model_pick();
    if (!m_locked) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        int r;
        r = (m_ptr + i) % REQ_NUM;
        if (bus.req_v_i[r] && bus.req_head_i[r] && can_send(r)) return r;
      end
      return -1;
    end
    if (bus.req_v_i[m_owner] && can_send(m_owner)) return m_owner;
    return -1;
  endfunction

  task automatic model_advance(input int win);
    int sent_vc;
    int rv;
    sent_vc = -1;
    rv      = -1;
    if (!m_locked)
      for (int r = 0; r < REQ_NUM; r++)
        if (bus.req_v_i[r] && !bus.req_head_i[r]) m_err = 1'b1;
    if (win >= 0) begin
      exp_q.push_back({bus.req_flit_i[win], bus.req_vc_id_i[win], bus.req_lar_i[win]});
      sent_vc = int'(bus.req_vc_id_i[win]);
      if (bus.req_tail_i[win]) begin
        m_locked = 1'b0;
        m_ptr    = (win + 1) % REQ_NUM;
      end else begin
        m_locked = 1'b1;
        m_owner  = win;
      end
    end
    m_exp_v = (win >= 0);
    if (bus.rx_lcrd_v_i) begin
      rv = int'(bus.rx_lcrd_id_i);
      if (rv >= VC_NUM) m_err = 1'b1;
      else if (rv != sent_vc) begin
        if (m_cred[rv] == VC_DEPTH) m_err = 1'b1;
        else m_cred[rv]++;
      end
    end
    if (sent_vc >= 0 && rv != sent_vc) m_cred[sent_vc]--;
  endtask

  // Single compare process: registered outputs against the model's previous step, then the grant.
  always @(negedge clk) begin
    if (!rstn) begin
      model_reset();
      m_last_win = -1;
    end else begin
      int win;
      logic [REQ_NUM-1:0] exp_rdy;
      check("tx_v", bus.tx_flit_v_o, m_exp_v);
      if (m_exp_v)
        check("tx_data", {bus.tx_flit_o, bus.tx_flit_vc_id_o, bus.tx_flit_look_ahead_routing_o},
              exp_q.pop_front());
      for (int v = 0; v < VC_NUM; v++)
        check($sformatf("credit%0d", v), bus.dbg_credit[v], m_cred[v]);
      check("err", bus.credit_err_o, m_err);
      check("state", bus.dbg_state, m_locked ? ST_LOCKED : ST_IDLE);
      win     = model_pick();
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      check("rdy", bus.req_rdy_o, exp_rdy);
      check("pend", bus.tx_flit_pend_o, |bus.req_v_i);
      model_advance(win);
      m_last_win = win;
    end
  end

  // ---------------- driver ----------------
  int rem[REQ_NUM];
  int pos[REQ_NUM];
  int vcs[REQ_NUM];
  int pid[REQ_NUM];
  bit hold[REQ_NUM];
  bit auto1[REQ_NUM];
  io_port_t lar[REQ_NUM];
  int occ[VC_NUM];
  int ret_vc = -1;
  int acc_r = -1;
  int pkt_cnt = 0;

  task automatic start_pkt(input int r, input int len, input int vc);
    rem[r] = len;
    pos[r] = 0;
    vcs[r] = vc;
    pid[r] = pkt_cnt++;
    lar[r] = io_port_t'($urandom_range(0, 7));
  endtask

  task automatic drive();
    for (int r = 0; r < REQ_NUM; r++) begin
      bus.req_v_i[r]     = (rem[r] > 0) && !hold[r];
      bus.req_head_i[r]  = (pos[r] == 0);
      bus.req_tail_i[r]  = (rem[r] == 1);
      bus.req_flit_i[r]  = {8'(r), 8'(pid[r]), 16'(pos[r])};
      bus.req_vc_id_i[r] = VC_ID_W'(vcs[r]);
      bus.req_lar_i[r]   = lar[r];
    end
    if (ret_vc >= 0) begin
      bus.rx_lcrd_v_i  = 1'b1;
      bus.rx_lcrd_id_i = VC_ID_W'(ret_vc);
      ret_vc = -1;
    end else begin
      bus.rx_lcrd_v_i  = 1'b0;
      bus.rx_lcrd_id_i = '0;
    end
  endtask

  // One cycle: consume the accept the model saw at this edge, then present the next inputs.
  task automatic step();
    @(posedge clk);
    #1;
    acc_r = m_last_win;
    if (acc_r >= 0 && rem[acc_r] > 0) begin
      occ[vcs[acc_r]]++;
      pos[acc_r]++;
      rem[acc_r]--;
      if (rem[acc_r] == 0 && auto1[acc_r]) start_pkt(acc_r, 1, vcs[acc_r]);
    end
    drive();
  endtask

  task automatic do_reset();
    for (int r = 0; r < REQ_NUM; r++) begin
      rem[r] = 0; pos[r] = 0; vcs[r] = 0; pid[r] = 0; hold[r] = 1'b0; auto1[r] = 1'b0; lar[r] = '0;
    end
    for (int v = 0; v < VC_NUM; v++) occ[v] = 0;
    ret_vc = -1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    drive();
    #2;
    check("rst_tx_v", bus.tx_flit_v_o, 0);
    check("rst_tx_flit", bus.tx_flit_o, 0);
    check("rst_tx_vc", bus.tx_flit_vc_id_o, 0);
    check("rst_tx_lar", bus.tx_flit_look_ahead_routing_o, 0);
    check("rst_err", bus.credit_err_o, 0);
    check("rst_state", bus.dbg_state, ST_IDLE);
    for (int v = 0; v < VC_NUM; v++) check("rst_credit", bus.dbg_credit[v], VC_DEPTH);
    step();
    step();
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    drive();

    // Single-flit packet on VC1, then its credit comes back.
    do_reset();
    start_pkt(0, 1, 1);
    step();
    step();
    check("t1_acc", acc_r, 0);
    check("t1_tx_v", bus.tx_flit_v_o, 1);
    check("t1_tx_vc", bus.tx_flit_vc_id_o, 1);
    check("t1_credit_after_send", bus.dbg_credit[1], 3);
    ret_vc = 1;
    step();
    step();
    check("t1_credit_after_return", bus.dbg_credit[1], 4);

    // Four continuous single-flit requesters: strict rotation, one grant per cycle.
    do_reset();
    for (int r = 0; r < REQ_NUM; r++) begin
      start_pkt(r, 1, r);
      auto1[r] = 1'b1;
    end
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_grant", acc_r, i % REQ_NUM);
    end

    // 3-flit wormhole packet from requester 2 is contiguous; requester 0 follows.
    do_reset();
    start_pkt(2, 3, 2);
    step();
    start_pkt(0, 1, 0);
    step();
    check("t3_head", acc_r, 2);
    check("t3_locked", bus.dbg_state, ST_LOCKED);
    step();
    check("t3_body", acc_r, 2);
    step();
    check("t3_tail", acc_r, 2);
    step();
    check("t3_next", acc_r, 0);

    // VC0 credit exhaustion and recovery.
    do_reset();
    start_pkt(1, 1, 0);
    auto1[1] = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_acc", acc_r, 1);
    end
    auto1[1] = 1'b0;
    step();
    check("t4_stall", acc_r, -1);
    check("t4_credit0", bus.dbg_credit[0], 0);
    ret_vc = 0;
    step();
    check("t4_stall_ret_cycle", acc_r, -1);
    step();
    check("t4_stall_ret_lands", acc_r, -1);
    check("t4_credit_back", bus.dbg_credit[0], 1);
    step();
    check("t4_resume", acc_r, 1);
    check("t4_credit_used", bus.dbg_credit[0], 0);

    // Same-cycle send/return, then overflow return.
    do_reset();
    start_pkt(0, 1, 3);
    step();
    step();
    check("t5_first", bus.dbg_credit[3], 3);
    start_pkt(0, 1, 3);
    ret_vc = 3;
    step();
    step();
    check("t5_acc", acc_r, 0);
    check("t5_same_cycle", bus.dbg_credit[3], 3);
    ret_vc = 3;
    step();
    step();
    check("t5_refill", bus.dbg_credit[3], 4);
    check("t5_no_err", bus.credit_err_o, 0);
    ret_vc = 3;
    step();
    step();
    check("t5_overflow_err", bus.credit_err_o, 1);
    check("t5_saturate", bus.dbg_credit[3], 4);

    // Illegal return id.
    do_reset();
    ret_vc = 5;
    step();
    step();
    check("illegal_id_err", bus.credit_err_o, 1);

    // Body flit offered while idle.
    do_reset();
    start_pkt(3, 1, 0);
    pos[3] = 1;
    step();
    step();
    check("nonhead_no_acc", acc_r, -1);
    check("nonhead_err", bus.credit_err_o, 1);

    // Reset in the middle of a locked packet.
    do_reset();
    start_pkt(1, 4, 0);
    step();
    step();
    step();
    check("t6_locked", bus.dbg_state, ST_LOCKED);
    rstn = 1'b0;
    #1;
    check("t6_rst_tx_v", bus.tx_flit_v_o, 0);
    check("t6_rst_state", bus.dbg_state, ST_IDLE);
    check("t6_rst_credit0", bus.dbg_credit[0], VC_DEPTH);
    for (int r = 0; r < REQ_NUM; r++) rem[r] = 0;
    drive();
    step();
    rstn = 1'b1;
    start_pkt(3, 1, 2);
    step();
    step();
    check("t6_new_grant", acc_r, 3);
    check("t6_new_vc", bus.tx_flit_vc_id_o, 2);

    // Random traffic with a credit-returning router model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < REQ_NUM; r++) begin
        if (rem[r] == 0 && $urandom_range(0, 3) == 0)
          start_pkt(r, $urandom_range(1, 4), $urandom_range(0, VC_NUM - 1));
        hold[r] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 1) == 1) begin
        int v;
        v = $urandom_range(0, VC_NUM - 1);
        if (occ[v] > 0) begin
          occ[v]--;
          ret_vc = v;
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, required completion before 1000000");
    $fatal(1, "timeout");
  end

endmodule
